// File: rtl/rx2inbox.sv
// rx2inbox: buffers UART receive bytes in a circular FIFO and drains them into the CPU INBOX.
//   clk        system clock
//   i_rst_n    asynchronous active-low reset
//   i_wr       byte strobe from the UART receiver, with i_data
//   i_full     INBOX full flag; a pop is blocked while it is high
//   i_clr_ovr  clears the sticky overrun flag
//   o_wr       INBOX write strobe, with o_data; never high two cycles running
//   o_count    FIFO occupancy 0..2^LOG2_DEPTH
//   o_empty    occupancy is zero
//   o_overrun  sticky: a byte was dropped because the FIFO was full
module rx2inbox #(
  parameter int LOG2_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  i_rst_n,
  input  logic                  i_wr,
  input  logic [7:0]            i_data,
  input  logic                  i_full,
  input  logic                  i_clr_ovr,
  output logic                  o_wr,
  output logic [7:0]            o_data,
  output logic [LOG2_DEPTH:0]   o_count,
  output logic                  o_empty,
  output logic                  o_overrun
);
  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam logic [LOG2_DEPTH:0] DEPTH_C = (LOG2_DEPTH+1)'(DEPTH);
  logic [7:0]            mem_q [DEPTH];
  logic [LOG2_DEPTH-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LOG2_DEPTH:0]   count_q, count_d;
  logic                  wr_q, wr_d, ovr_q, ovr_d;
  logic [7:0]            data_q, data_d;
  logic                  pop, push, drop;
  // Pop is gated by the previous write so the INBOX full flag can catch up.
  assign pop  = (count_q != '0) && !i_full && !wr_q;
  // A full FIFO still accepts a byte when a slot is freed in the same cycle.
  assign push = i_wr && (count_q != DEPTH_C || pop);
  assign drop = i_wr && !push;
  always_comb begin
    wptr_d  = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = pop ? rptr_q + 1'b1 : rptr_q;
    count_d = (push && !pop) ? count_q + 1'b1 : (pop && !push) ? count_q - 1'b1 : count_q;
    wr_d    = pop;
    data_d  = pop ? mem_q[rptr_q] : data_q;
    ovr_d   = drop ? 1'b1 : i_clr_ovr ? 1'b0 : ovr_q;
  end
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      wr_q    <= 1'b0;
      data_q  <= 8'h00;
      ovr_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      wr_q    <= wr_d;
      data_q  <= data_d;
      ovr_q   <= ovr_d;
    end
  end
  // Storage is left uncleared by reset; stale entries are unreachable once the pointers reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= i_data;
  end
  assign o_wr      = wr_q;
  assign o_data    = data_q;
  assign o_count   = count_q;
  assign o_empty   = count_q == '0;
  assign o_overrun = ovr_q;
endmodule

// File: tb/tb_rx2inbox.sv
// tb_rx2inbox: scoreboard bench for rx2inbox; stimulus queues expected bytes, a monitor checks INBOX writes.
module tb_rx2inbox;
  logic       clk = 1'b0;
  logic       i_rst_n, i_wr, i_full, i_clr_ovr;
  logic [7:0] i_data;
  logic       o_wr, o_empty, o_overrun;
  logic [7:0] o_data;
  logic [4:0] o_count;
  logic [7:0] exp_q [$];
  logic [7:0] e;
  logic       prev_wr = 1'b0;
  int         checks = 0;
  int         errors = 0;
  rx2inbox #(.LOG2_DEPTH(4)) dut (
    .clk(clk), .i_rst_n(i_rst_n), .i_wr(i_wr), .i_data(i_data), .i_full(i_full),
    .i_clr_ovr(i_clr_ovr), .o_wr(o_wr), .o_data(o_data), .o_count(o_count),
    .o_empty(o_empty), .o_overrun(o_overrun)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  // Called at posedge+1; returns at the following posedge+1.
  task automatic push(input logic [7:0] b, input bit accept);
    i_wr = 1'b1;
    i_data = b;
    if (accept) exp_q.push_back(b);
    @(posedge clk);
    #1 i_wr = 1'b0;
  endtask
  task automatic drain(input string n);
    int k = 0;
    while ((exp_q.size() != 0 || o_count != 0) && k < 200) begin
      @(posedge clk);
      #1 k++;
    end
    chk(n, exp_q.size(), 0);
    chk({n, "_count"}, int'(o_count), 0);
  endtask
  always @(negedge clk) begin
    if (i_rst_n) begin
      if (o_wr) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_wr: got data %0h expected no write", o_data);
        end else begin
          e = exp_q.pop_front();
          if (o_data !== e) begin
            errors++;
            $display("FAIL out_data: got %0h expected %0h", o_data, e);
          end
        end
        checks++;
        if (prev_wr) begin
          errors++;
          $display("FAIL pacing: got o_wr high 2 cycles expected 1");
        end
      end
      prev_wr = o_wr;
    end else prev_wr = 1'b0;
  end
  initial begin
    i_rst_n = 1'b0; i_wr = 1'b0; i_data = 8'h00; i_full = 1'b0; i_clr_ovr = 1'b0;
    #12;
    chk("rst_count", int'(o_count), 0);
    chk("rst_empty", int'(o_empty), 1);
    chk("rst_wr", int'(o_wr), 0);
    chk("rst_ovr", int'(o_overrun), 0);
    #5 i_rst_n = 1'b1;
    @(posedge clk);
    #1;
    // single byte, 2-clock latency
    push(8'h41, 1);
    @(negedge clk);
    chk("single_wr_n1", int'(o_wr), 0);
    chk("single_count", int'(o_count), 1);
    @(negedge clk);
    chk("single_wr_n2", int'(o_wr), 1);
    chk("single_data", int'(o_data), 8'h41);
    @(posedge clk);
    #1;
    drain("single_drain");
    chk("single_ovr", int'(o_overrun), 0);
    // back-pressure order
    i_full = 1'b1;
    for (int i = 1; i <= 5; i++) push(8'(i), 1);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_count", int'(o_count), 5);
    chk("bp_no_wr", int'(o_wr), 0);
    i_full = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("bp_in_10clk", exp_q.size(), 0);
    drain("bp_drain");
    // overflow
    i_full = 1'b1;
    for (int i = 0; i < 16; i++) push(8'(8'h20 + i), 1);
    push(8'hEE, 0);
    @(negedge clk);
    chk("ovf_count", int'(o_count), 16);
    chk("ovf_ovr", int'(o_overrun), 1);
    @(posedge clk);
    #1 i_clr_ovr = 1'b1;
    @(posedge clk);
    #1 i_clr_ovr = 1'b0;
    chk("ovf_clr", int'(o_overrun), 0);
    // simultaneous push/pop at full
    i_full = 1'b0;
    push(8'hAA, 1);
    chk("simul_count", int'(o_count), 16);
    chk("simul_ovr", int'(o_overrun), 0);
    chk("simul_wr", int'(o_wr), 1);
    drain("ovf_drain");
    // wrap-around with toggling back-pressure
    for (int c = 0; c < 120; c++) begin
      i_full = (c % 5 == 0);
      if (c % 3 == 0) push(8'(c * 7 + 3), 1);
      else begin
        @(posedge clk);
        #1;
      end
    end
    i_full = 1'b0;
    drain("wrap_drain");
    chk("wrap_ovr", int'(o_overrun), 0);
    // reset mid-operation
    i_full = 1'b1;
    for (int i = 0; i < 6; i++) push(8'(8'h60 + i), 1);
    chk("rstm_count", int'(o_count), 6);
    #2 i_rst_n = 1'b0;
    #1;
    chk("rstm_count0", int'(o_count), 0);
    chk("rstm_empty", int'(o_empty), 1);
    chk("rstm_wr", int'(o_wr), 0);
    chk("rstm_data", int'(o_data), 0);
    exp_q.delete();
    #3 i_rst_n = 1'b1;
    @(posedge clk);
    #1 i_full = 1'b0;
    push(8'h7E, 1);
    drain("rstm_drain");
    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
